full_adder_eight_bit: RTL and testbench
=======================================

// Module: full_adder_eight_bit
// PURPOSE
//  8-bit ripple-carry adder built from eight 1-bit full-adder cells; datapath primitive
//  for ALU/accumulator blocks. Provides a combinational result (sum/cout) plus a
//  registered copy of the result and flags for pipelined consumers.
//  One clock; the register stage is the only sequential logic.
// PARAMETERS
//  none (width fixed at 8 bits)
// PORTS
//  clk     in   1  rising-edge clock for the output register stage
//  rst     in   1  asynchronous, active-high reset; clears registered outputs
//  a       in   8  operand A, unsigned (two's-complement for ovf)
//  b       in   8  operand B
//  cin     in   1  carry into bit 0
//  sum     out  8  combinational (a + b + cin) mod 256
//  cout    out  1  combinational carry out of bit 7
//  ovf     out  1  combinational signed overflow = carry into bit7 XOR carry out of bit7
//  sum_q   out  8  sum registered on clk
//  cout_q  out  1  cout registered on clk
//  ovf_q   out  1  ovf registered on clk
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is asynchronous and active-high.
//  - Cell i: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]); c[0]=cin.
//  - sum = s[7:0]; cout = c[8]; {cout,sum} == a + b + cin exactly (9-bit result).
//  - sum/cout/ovf: purely combinational, zero cycles of latency, independent of clk/rst;
//    valid after ripple settles with no clock edge required.
//  - Registered outputs: on each rising clk edge, sum_q<=sum, cout_q<=cout, ovf_q<=ovf;
//    latency 1 cycle; no enable, loads every cycle.
//  - rst asserted (any time, no clock needed): sum_q=8'h00, cout_q=0, ovf_q=0 immediately;
//    held while rst=1; first load on first rising edge after rst deasserts.
//  - Reset does not affect combinational sum/cout/ovf.
//  - Wrap-around: 8'hFF+8'h01 -> sum 8'h00, cout 1; 8'hFF+8'hFF+1 -> 8'hFF, cout 1.
//  - X/Z on inputs is not a supported condition; no internal state beyond the registers.
// TESTING
//  - a=8'h01,b=8'h01,cin=0 -> sum=8'h02,cout=0; cin=1 -> sum=8'h03,cout=0 (no clock).
//  - a=8'h81,b=8'h81,cin=0 -> sum=8'h02,cout=1,ovf=1; a=8'h19,b=8'h31 -> 8'h4A,cout=0.
//  - a=8'hFF,b=8'h01,cin=0 -> 8'h00,cout=1; a=8'hFF,b=8'h00,cin=1 -> 8'h00,cout=1.
//  - a=8'hFF,b=8'hFF,cin=0 -> sum=8'hFE,cout=1,ovf=0; a=8'h7F,b=8'h01 -> 8'h80,ovf=1.
//  - rst=1 mid-run with sum_q!=0 -> sum_q/cout_q/ovf_q=0 before next edge; release,
//    a=8'h03,b=8'h03,cin=1 -> after 1 edge sum_q=8'h07,cout_q=0.
//  - Exhaustive sweep of a,b (65536) x cin -> {cout,sum}==a+b+cin; registered copies match 1 cycle later.

Source files
------------

// File: rtl/full_adder_eight_bit.sv
// full_adder_eight_bit
// 8-bit ripple-carry adder made of eight 1-bit full-adder cells.
// sum/cout/ovf are purely combinational.
// sum_q/cout_q/ovf_q hold a copy of the result, registered every clock,
// for pipelined consumers.
module full_adder_eight_bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       ovf,
    output logic [7:0] sum_q,
    output logic       cout_q,
    output logic       ovf_q
);

    // Carry chain: c[i] is the carry into cell i, so c[0] = cin and c[8] = cout.
    logic [8:0] c;
    logic [7:0] s;

    // Ripple the carry through the eight full-adder cells, starting at bit 0.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    // Signed overflow: the carry into the sign bit differs from the carry out of it.
    assign sum  = s;
    assign cout = c[8];
    assign ovf  = c[7] ^ c[8];

    logic [7:0] sum_d;
    logic       cout_d;
    logic       ovf_d;

    // Next-state values for the output register stage (loads every cycle).
    always_comb begin
        sum_d  = sum;
        cout_d = cout;
        ovf_d  = ovf;
    end

    // Output register stage; the asynchronous reset clears it immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= 8'h00;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_full_adder_eight_bit.sv
// Testbench for full_adder_eight_bit: a scoreboard of expected registered results,
// directed corner cases, the asynchronous reset, and an exhaustive
// combinational sweep.
module tb_full_adder_eight_bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic [7:0] sum_q;
    logic       cout_q;
    logic       ovf_q;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard of expected registered results, packed as {ovf, cout, sum}.
    logic [9:0] exp_q[$];

    full_adder_eight_bit dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf),
        .sum_q  (sum_q),
        .cout_q (cout_q),
        .ovf_q  (ovf_q)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {ovf,cout,sum}=%h expected %h (a=%h b=%h cin=%b)",
                     tag, got, exp, a, b, cin);
        end
    endtask

    // Reference: 9-bit arithmetic sum; signed overflow when the operands share a sign
    // that the result does not.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci);
        logic [8:0] t;
        logic       o;
        t = {1'b0, x} + {1'b0, y} + {8'b0, ci};
        o = (x[7] == y[7]) && (t[7] != x[7]);
        return {o, t};
    endfunction

    // Apply one vector after a falling edge, check the combinational result before
    // any clock edge, push the expectation, then check the registered copy after
    // the next rising edge.
    task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic ci,
                         input logic [9:0] exp, input string tag);
        @(negedge clk);
        a   = x;
        b   = y;
        cin = ci;
        #1;
        check_eq({tag, "_comb"}, {ovf, cout, sum}, exp);
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check_eq({tag, "_reg"}, {ovf_q, cout_q, sum_q}, exp_q.pop_front());
    endtask

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       ci;
        logic [9:0] exp;
        string      tag;
    } vec_t;

    vec_t dir_tab[$];

    initial begin
        dir_tab = '{
            '{8'h01, 8'h01, 1'b0, 10'h002, "one_plus_one"},
            '{8'h01, 8'h01, 1'b1, 10'h003, "one_plus_one_cin"},
            '{8'h81, 8'h81, 1'b0, 10'h302, "neg_ovf"},
            '{8'h19, 8'h31, 1'b0, 10'h04A, "mid_values"},
            '{8'hFF, 8'h01, 1'b0, 10'h100, "wrap_ff_01"},
            '{8'hFF, 8'h00, 1'b1, 10'h100, "wrap_ff_cin"},
            '{8'hFF, 8'hFF, 1'b0, 10'h1FE, "ff_ff"},
            '{8'hFF, 8'hFF, 1'b1, 10'h1FF, "ff_ff_cin"},
            '{8'h7F, 8'h01, 1'b0, 10'h280, "pos_ovf"},
            '{8'h80, 8'h80, 1'b0, 10'h300, "min_min"},
            '{8'h55, 8'hAA, 1'b1, 10'h100, "alt_bits_cin"}
        };

        // Reset from time zero: registered outputs cleared with no clock edge yet.
        rst = 1'b1;
        a   = 8'h00;
        b   = 8'h00;
        cin = 1'b0;
        #2;
        check_eq("reset_no_edge", {ovf_q, cout_q, sum_q}, 10'h000);

        // Combinational path works while reset is held.
        a   = 8'h81;
        b   = 8'h81;
        #1;
        check_eq("comb_in_reset", {ovf, cout, sum}, 10'h302);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_held", {ovf_q, cout_q, sum_q}, 10'h000);

        @(negedge clk);
        rst = 1'b0;

        foreach (dir_tab[i])
            drive(dir_tab[i].x, dir_tab[i].y, dir_tab[i].ci, dir_tab[i].exp, dir_tab[i].tag);

        // Mid-run reset: load a non-zero value, then reset between edges.
        drive(8'hFF, 8'hFF, 1'b1, 10'h1FF, "pre_reset");
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("async_reset", {ovf_q, cout_q, sum_q}, 10'h000);
        check_eq("comb_during_reset", {ovf, cout, sum}, 10'h1FF);
        @(posedge clk);
        #1;
        check_eq("reset_over_edge", {ovf_q, cout_q, sum_q}, 10'h000);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(8'h03, 8'h03, 1'b1, 10'h007, "after_reset");

        // Random clocked vectors through the scoreboard.
        for (int k = 0; k < 400; k++) begin
            logic [7:0] x;
            logic [7:0] y;
            logic       ci;
            x  = 8'($urandom_range(0, 255));
            y  = 8'($urandom_range(0, 255));
            ci = 1'($urandom_range(0, 1));
            drive(x, y, ci, model(x, y, ci), "random");
        end

        // Exhaustive combinational sweep, one vector per nanosecond.
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 0; bi < 256; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a   = 8'(ai);
                    b   = 8'(bi);
                    cin = 1'(ci);
                    #1;
                    check_eq("sweep", {ovf, cout, sum}, model(8'(ai), 8'(bi), 1'(ci)));
                end
            end
        end

        // Registered copy after the sweep reflects the last vector.
        @(posedge clk);
        #1;
        check_eq("sweep_reg", {ovf_q, cout_q, sum_q}, model(8'hFF, 8'hFF, 1'b1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
